i2c_reg_master: RTL
===================

Name: i2c_reg_master

Overview:
- Register-access sequencer that sits directly upstream of the i2c core.
- Accepts one register read or write request at a time and breaks it into the core's byte-level controls: transfer_start, transfer_continues, mode and data_tx.
- Consumes the core's transfer_ready, transaction_complete, nack, data_rx, start_err and arbitration_err, and returns one response per request with status and read data.

Parameters:
- TIMEOUT_CYCLES, 1000000, clk_in cycles allowed between request acceptance and each byte completion before a bus error is declared.
- TW, $clog2(TIMEOUT_CYCLES+1), width of the watchdog counter (derived; not overridden).

Ports:
- clk_in  in  1  same clock as the i2c core.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block idle; request accepted when req_valid && req_ready.
- req_rw  in  1  0 = write, 1 = read.
- req_dev_addr  in  7  7-bit slave address.
- req_reg_addr  in  8  register index.
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle pulse per accepted request.
- rsp_status  out  2  0 OK, 1 NACK_ADDR, 2 NACK_DATA, 3 BUS_ERR.
- rsp_rdata  out  8  read data; valid when rsp_valid, read and status OK.
- transfer_start, transfer_continues, mode  out  1 each  to the core.
- data_tx  out  8  to the core.
- transfer_ready, transaction_complete, nack, start_err, arbitration_err  in  1 each  from the core.
- data_rx  in  8  from the core.

Behaviour:
- Reset values:
  - req_ready=1; rsp_valid=0, rsp_status=0, rsp_rdata=0.
  - transfer_start=0, transfer_continues=0, mode=0, data_tx=0.
  - State = IDLE; watchdog = 0.
- All outputs are registered.
- Core controls (the "next-byte descriptor") change only on:
  - the acceptance cycle, or
  - the cycle after transaction_complete or an error.
- Otherwise the descriptor is held stable. The core samples it at arbitrary later points (ACK phase, repeated START).
- States: IDLE, START, ADDR_W, REG, WDATA, ADDR_R, RDATA, DRAIN.
- IDLE:
  - On accept, latch the request and load descriptor {start=1, cont=1, mode=0, data={dev,0}}.
  - Go to START.
- START: on transfer_ready && transfer_start, go to ADDR_W. The byte is now owned by the core.
- Byte states advance on transaction_complete:
  - ADDR_W, nack=1: descriptor start=0 (forces STOP), rsp NACK_ADDR, go to DRAIN.
  - ADDR_W, nack=0: descriptor {start=1, cont=1, mode=0, data=reg}, go to REG.
  - REG, write: {start=0, cont=1, mode=0, data=wdata}, go to WDATA.
  - REG, read: {start=1, cont=0, data=reg} must already be latched by the core. So on REG entry for a read, descriptor cont=0, start=1.
  - REG completion (read): load {start=1, cont=1, mode=0, data={dev,1}} for the repeated START, go to ADDR_R.
  - REG, nack=1: start=0, rsp NACK_DATA, go to DRAIN.
  - WDATA: start=0, rsp OK or NACK_DATA per nack, go to DRAIN.
  - ADDR_R, nack=0: {start=0, cont=0, mode=1}. The core then NACKs the final read byte and issues STOP. Go to RDATA.
  - ADDR_R, nack=1: start=0, rsp NACK_ADDR, go to DRAIN.
  - RDATA: capture data_rx into rsp_rdata in the same cycle as transaction_complete, rsp OK, go to DRAIN.
- Descriptor timing rule: the continues flag for a byte is the one presented when that byte is latched by the core. The descriptor loaded on a completion therefore carries the next byte's data and continues flag.
- DRAIN:
  - rsp_valid has already pulsed.
  - Wait for transfer_ready, meaning the STOP and bus-free time are done.
  - Then go to IDLE with req_ready=1.
- req_ready is 1 only in IDLE.
- Errors:
  - start_err or arbitration_err in any non-IDLE state: descriptor cleared, rsp BUS_ERR, go to DRAIN.
  - An error has priority over a simultaneous transaction_complete.
- Watchdog:
  - Cleared on accept and on every transaction_complete.
  - Counts in START..RDATA and in DRAIN.
  - Saturates at TIMEOUT_CYCLES.
  - On reaching it: rsp BUS_ERR (none is issued if in DRAIN) and force IDLE.
- Exactly one rsp_valid per accepted request. No rsp_valid in DRAIN or IDLE.
- Reset mid-transfer:
  - The block returns to IDLE and drops transfer_start.
  - The core (unreset) finishes the current byte and STOPs.
  - A new request waits in START for transfer_ready.

Decomposition:
- Package i2c_pkg holds:
  - typedef enum rsp_status_t {OK, NACK_ADDR, NACK_DATA, BUS_ERR};
  - the state enum;
  - the read/write bit constants.
- Sub-module i2c_watchdog: clear/enable inputs and an expired output, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Write dev=0x50 reg=0x10 data=0xA5 with an ACKing slave model:
  - bus bytes 0xA0, 0x10, 0xA5, then STOP;
  - rsp_status=0;
  - req_ready returns after transfer_ready.
- Read dev=0x50 reg=0x10, slave returns 0x3C:
  - bytes 0xA0, 0x10, repeated START, 0xA1, read with master NACK, STOP;
  - rsp_rdata=0x3C, status 0.
- Absent slave (address NACK) on a write:
  - rsp_status=1 after the first byte;
  - STOP issued; no further bytes.
- Slave NACKs the register byte on a read: rsp_status=2, and no repeated START is seen.
- arbitration_err pulse during REG:
  - rsp_status=3 within 1 cycle;
  - transfer_start=0;
  - block IDLE after the next transfer_ready.
- TIMEOUT_CYCLES=100 with transaction_complete held low: rsp_status=3 after 100 cycles; then back-to-back requests and rst_n low mid-byte leave req_ready=1 and all outputs at reset values.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the i2c register-access sequencer.
package i2c_pkg;

    typedef enum logic [1:0] {
        OK        = 2'd0,
        NACK_ADDR = 2'd1,
        NACK_DATA = 2'd2,
        BUS_ERR   = 2'd3
    } rsp_status_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        ADDR_W = 3'd2,
        REG    = 3'd3,
        WDATA  = 3'd4,
        ADDR_R = 3'd5,
        RDATA  = 3'd6,
        DRAIN  = 3'd7
    } state_t;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    // Next-byte descriptor presented to the i2c core.
    typedef struct packed {
        logic       start;
        logic       cont;
        logic       mode;
        logic [7:0] data;
    } desc_t;

    function automatic desc_t mk_desc(input logic start, input logic cont,
                                      input logic mode, input logic [7:0] data);
        desc_t d;
        d.start = start;
        d.cont  = cont;
        d.mode  = mode;
        d.data  = data;
        return d;
    endfunction

endpackage

// File: rtl/i2c_watchdog.sv
// Saturating cycle counter that flags a stalled transfer.
module i2c_watchdog #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] ONE   = {{(TW-1){1'b0}}, 1'b1};

    logic [TW-1:0] count_q;

    // Count while enabled, hold at the limit, restart on clear.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i && (count_q != LIMIT)) begin
            count_q <= count_q + ONE;
        end
    end

    assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/i2c_reg_master.sv
// Breaks one register read/write request into i2c core byte descriptors
// and returns a single status/data response per request.
module i2c_reg_master
    import i2c_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_dev_addr,
    input  logic [7:0] req_reg_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [1:0] rsp_status,
    output logic [7:0] rsp_rdata,
    output logic       transfer_start,
    output logic       transfer_continues,
    output logic       mode,
    output logic [7:0] data_tx,
    input  logic       transfer_ready,
    input  logic       transaction_complete,
    input  logic       nack,
    input  logic       start_err,
    input  logic       arbitration_err,
    input  logic [7:0] data_rx
);
    state_t      state_q;
    logic        rw_q;
    logic [6:0]  dev_q;
    logic [7:0]  reg_q;
    logic [7:0]  wdata_q;
    desc_t       desc_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    rsp_status_t rsp_status_q;
    logic [7:0]  rsp_rdata_q;

    logic accept_s;
    logic wd_clear_s;
    logic wd_en_s;
    logic wd_expired_s;
    logic bus_err_s;

    assign accept_s   = req_valid && req_ready_q && (state_q == IDLE);
    assign wd_clear_s = accept_s || transaction_complete;
    assign wd_en_s    = (state_q != IDLE);
    assign bus_err_s  = start_err || arbitration_err;

    i2c_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .clear_i  (wd_clear_s),
        .enable_i (wd_en_s),
        .expired_o(wd_expired_s)
    );

    // Sequencer: descriptor only changes on accept, completion or error; responses pulse once.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rw_q         <= RW_WRITE;
            dev_q        <= 7'd0;
            reg_q        <= 8'd0;
            wdata_q      <= 8'd0;
            desc_q       <= '0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= OK;
            rsp_rdata_q  <= 8'd0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (state_q == IDLE) begin
                req_ready_q <= 1'b1;
                if (accept_s) begin
                    rw_q        <= req_rw;
                    dev_q       <= req_dev_addr;
                    reg_q       <= req_reg_addr;
                    wdata_q     <= req_wdata;
                    desc_q      <= mk_desc(1'b1, 1'b1, 1'b0, {req_dev_addr, RW_WRITE});
                    req_ready_q <= 1'b0;
                    state_q     <= START;
                end
            end else if (wd_expired_s) begin
                // DRAIN already responded; otherwise report the stall.
                if (state_q != DRAIN) begin
                    rsp_valid_q  <= 1'b1;
                    rsp_status_q <= BUS_ERR;
                end
                desc_q      <= '0;
                req_ready_q <= 1'b1;
                state_q     <= IDLE;
            end else if (bus_err_s) begin
                if (state_q != DRAIN) begin
                    rsp_valid_q  <= 1'b1;
                    rsp_status_q <= BUS_ERR;
                end
                desc_q  <= '0;
                state_q <= DRAIN;
            end else begin
                case (state_q)
                    START: begin
                        if (transfer_ready && desc_q.start) begin
                            state_q <= ADDR_W;
                        end
                    end
                    ADDR_W: begin
                        if (transaction_complete) begin
                            if (nack) begin
                                desc_q.start <= 1'b0;
                                rsp_valid_q  <= 1'b1;
                                rsp_status_q <= NACK_ADDR;
                                state_q      <= DRAIN;
                            end else begin
                                // A read must end the register byte with cont=0 to get a repeated START.
                                desc_q  <= mk_desc(1'b1, (rw_q == RW_WRITE), 1'b0, reg_q);
                                state_q <= REG;
                            end
                        end
                    end
                    REG: begin
                        if (transaction_complete) begin
                            if (nack) begin
                                desc_q.start <= 1'b0;
                                rsp_valid_q  <= 1'b1;
                                rsp_status_q <= NACK_DATA;
                                state_q      <= DRAIN;
                            end else if (rw_q == RW_READ) begin
                                desc_q  <= mk_desc(1'b1, 1'b1, 1'b0, {dev_q, RW_READ});
                                state_q <= ADDR_R;
                            end else begin
                                desc_q  <= mk_desc(1'b0, 1'b1, 1'b0, wdata_q);
                                state_q <= WDATA;
                            end
                        end
                    end
                    WDATA: begin
                        if (transaction_complete) begin
                            desc_q.start <= 1'b0;
                            rsp_valid_q  <= 1'b1;
                            rsp_status_q <= nack ? NACK_DATA : OK;
                            state_q      <= DRAIN;
                        end
                    end
                    ADDR_R: begin
                        if (transaction_complete) begin
                            if (nack) begin
                                desc_q.start <= 1'b0;
                                rsp_valid_q  <= 1'b1;
                                rsp_status_q <= NACK_ADDR;
                                state_q      <= DRAIN;
                            end else begin
                                // Single read byte: core NACKs it and issues STOP.
                                desc_q  <= mk_desc(1'b0, 1'b0, 1'b1, desc_q.data);
                                state_q <= RDATA;
                            end
                        end
                    end
                    RDATA: begin
                        if (transaction_complete) begin
                            rsp_rdata_q  <= data_rx;
                            rsp_valid_q  <= 1'b1;
                            rsp_status_q <= OK;
                            state_q      <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (transfer_ready) begin
                            req_ready_q <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end
                    default: begin
                        desc_q      <= '0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                endcase
            end
        end
    end

    assign req_ready          = req_ready_q;
    assign rsp_valid          = rsp_valid_q;
    assign rsp_status         = rsp_status_q;
    assign rsp_rdata          = rsp_rdata_q;
    assign transfer_start     = desc_q.start;
    assign transfer_continues = desc_q.cont;
    assign mode               = desc_q.mode;
    assign data_tx            = desc_q.data;

endmodule
